// File: rtl/button_event_queue.sv
// Serializes per-channel edge pulses into a FIFO of channel indices, lowest
// channel first, with a sticky overflow flag for edges that merge into a pending bit.
module button_event_queue #(
    parameter int P_BUTTON_WIDTH = 5,
    parameter int P_IDX_WIDTH    = 3,
    parameter int P_DEPTH_LOG2   = 2
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic [P_BUTTON_WIDTH-1:0] iButtonEdge,
    output logic                      oEvtValid,
    output logic [P_IDX_WIDTH-1:0]    oEvtIdx,
    input  logic                      iEvtReady,
    output logic                      oOverflow,
    input  logic                      iClrOverflow,
    output logic [P_DEPTH_LOG2:0]     oCount
);

    localparam int DEPTH = 1 << P_DEPTH_LOG2;

    logic [P_BUTTON_WIDTH-1:0] pending_q, pending_d, grant;
    logic [P_IDX_WIDTH-1:0]    mem_q [DEPTH];
    logic [P_DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [P_DEPTH_LOG2:0]     count_q;
    logic                      overflow_q;
    logic                      full, push, pop, drop;
    logic [P_IDX_WIDTH-1:0]    grant_idx;

    // Scan high to low so the lowest set bit is the last assignment and wins.
    always_comb begin
        grant_idx = '0;
        for (int i = P_BUTTON_WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) grant_idx = P_IDX_WIDTH'(i);
        end
    end

    assign oEvtValid = (count_q != '0);
    assign full      = (count_q == (P_DEPTH_LOG2 + 1)'(DEPTH));
    assign pop       = oEvtValid & iEvtReady;
    assign push      = (|pending_q) & (~full | pop);
    assign grant     = push ? (pending_q & (~pending_q + P_BUTTON_WIDTH'(1))) : '0;
    // An edge on a still-pending, ungranted channel merges and is lost.
    assign drop      = |(iButtonEdge & pending_q & ~grant);
    assign pending_d = (pending_q & ~grant) | iButtonEdge;

    assign oEvtIdx   = mem_q[rd_ptr_q];
    assign oOverflow = overflow_q;
    assign oCount    = count_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            if (push) begin
                mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop)              overflow_q <= 1'b1;
            else if (iClrOverflow) overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench for button_event_queue: per-cycle vector table plus
// scoreboard-checked streaming and asynchronous reset sequences.
module tb_button_event_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] edge_i;
    logic       valid_o;
    logic [2:0] idx_o;
    logic       ready_i;
    logic       ovf_o;
    logic       clr_i;
    logic [2:0] count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] edges;
        logic       rdy;
        logic       clr;
        logic       exp_valid;
        logic [2:0] exp_idx;
        logic [2:0] exp_count;
        logic       exp_ovf;
    } vec_t;

    vec_t       vq[$];
    logic [2:0] sb[$];

    button_event_queue #(.P_BUTTON_WIDTH(5), .P_IDX_WIDTH(3), .P_DEPTH_LOG2(2)) dut (
        .iClk(clk), .iRst_n(rst_n), .iButtonEdge(edge_i),
        .oEvtValid(valid_o), .oEvtIdx(idx_o), .iEvtReady(ready_i),
        .oOverflow(ovf_o), .iClrOverflow(clr_i), .oCount(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [4:0] e, input logic r, input logic c,
                       input logic v, input logic [2:0] i, input logic [2:0] n, input logic o);
        vec_t t;
        t.edges = e; t.rdy = r; t.clr = c;
        t.exp_valid = v; t.exp_idx = i; t.exp_count = n; t.exp_ovf = o;
        vq.push_back(t);
    endtask

    // Drive at edge+1, sample at the following edge+1.
    task automatic cycle(input logic [4:0] e, input logic r, input logic c);
        edge_i = e; ready_i = r; clr_i = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; edge_i = '0; ready_i = 1'b0; clr_i = 1'b0;
        #12;
        chk("rst_valid", valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ovf",   ovf_o,   0);
        chk("rst_idx",   idx_o,   0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single pulse, hold, pop
        add(5'b00001, 0, 0, 0, 0, 0, 0);
        add(5'b00000, 0, 0, 1, 0, 1, 0);
        add(5'b00000, 0, 0, 1, 0, 1, 0);
        add(5'b00000, 1, 0, 0, 0, 0, 0);
        // simultaneous edges serialize lowest first
        add(5'b10101, 0, 0, 0, 0, 0, 0);
        add(5'b00000, 0, 0, 1, 0, 1, 0);
        add(5'b00000, 0, 0, 1, 0, 2, 0);
        add(5'b00000, 0, 0, 1, 0, 3, 0);
        add(5'b00000, 1, 0, 1, 2, 2, 0);
        add(5'b00000, 1, 0, 1, 4, 1, 0);
        add(5'b00000, 1, 0, 0, 0, 0, 0);
        // fill to depth, channel 4 waits in pending
        add(5'b00001, 0, 0, 0, 0, 0, 0);
        add(5'b00010, 0, 0, 1, 0, 1, 0);
        add(5'b00100, 0, 0, 1, 0, 2, 0);
        add(5'b01000, 0, 0, 1, 0, 3, 0);
        add(5'b10000, 0, 0, 1, 0, 4, 0);
        add(5'b00000, 0, 0, 1, 0, 4, 0);
        add(5'b00000, 0, 0, 1, 0, 4, 0);
        add(5'b00000, 1, 0, 1, 1, 4, 0);
        // drop while full, sticky flag, clear, clear loses to set
        add(5'b00010, 0, 0, 1, 1, 4, 0);
        add(5'b00010, 0, 0, 1, 1, 4, 1);
        add(5'b00000, 0, 0, 1, 1, 4, 1);
        add(5'b00000, 0, 1, 1, 1, 4, 0);
        add(5'b00010, 0, 1, 1, 1, 4, 1);
        add(5'b00000, 0, 1, 1, 1, 4, 0);
        // drain: pop+push at full keeps count
        add(5'b00000, 1, 0, 1, 2, 4, 0);
        add(5'b00000, 1, 0, 1, 3, 3, 0);
        add(5'b00000, 1, 0, 1, 4, 2, 0);
        add(5'b00000, 1, 0, 1, 1, 1, 0);
        add(5'b00000, 1, 0, 0, 0, 0, 0);

        for (int k = 0; k < vq.size(); k++) begin
            cycle(vq[k].edges, vq[k].rdy, vq[k].clr);
            chk($sformatf("v%0d_valid", k), valid_o, vq[k].exp_valid);
            chk($sformatf("v%0d_count", k), count_o, vq[k].exp_count);
            chk($sformatf("v%0d_ovf",   k), ovf_o,   vq[k].exp_ovf);
            if (vq[k].exp_valid)
                chk($sformatf("v%0d_idx", k), idx_o, vq[k].exp_idx);
        end

        // streaming: a different channel every cycle, consumer always ready
        for (int k = 0; k < 26; k++) begin
            logic [4:0] e;
            e = '0;
            if (k < 20) begin
                e[k % 5] = 1'b1;
                sb.push_back(3'(k % 5));
            end
            cycle(e, 1'b1, 1'b0);
            if (valid_o) begin
                if (sb.size() == 0) chk("stream_spurious", 1, 0);
                else chk($sformatf("stream_idx%0d", k), idx_o, sb.pop_front());
            end
            chk($sformatf("stream_cnt_le2_%0d", k), int'(count_o <= 3'd2), 1);
            chk($sformatf("stream_ovf%0d", k), ovf_o, 0);
        end
        chk("stream_all_out", sb.size(), 0);

        // async reset mid-operation with three events held and overflow set
        cycle(5'b00111, 0, 0);
        cycle(5'b00100, 0, 0);
        cycle(5'b00000, 0, 0);
        cycle(5'b00000, 0, 0);
        chk("pre_rst_count", count_o, 3);
        chk("pre_rst_ovf",   ovf_o,   1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", valid_o, 0);
        chk("async_rst_count", count_o, 0);
        chk("async_rst_ovf",   ovf_o,   0);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(5'b00000, 1, 0);
            chk($sformatf("post_rst_valid%0d", k), valid_o, 0);
            chk($sformatf("post_rst_count%0d", k), count_o, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_queue.md
Name: button_event_queue

Overview:
- Consumer end of the button edge interface: accepts the per-channel, one-cycle edge pulses produced by button_sync and turns them into an ordered stream of channel-index events.
- Events are buffered in a small FIFO behind a valid/ready handshake, so the control FSM can pop them at its own pace.
- Simultaneous edges on several channels are serialized, lowest index first; no event is lost silently.

Parameters:
- P_BUTTON_WIDTH, 5, number of edge channels (1..8).
- P_IDX_WIDTH, 3, width of the event index; must satisfy 2**P_IDX_WIDTH >= P_BUTTON_WIDTH.
- P_DEPTH_LOG2, 2, log2 of FIFO depth (depth = 4 by default; range 1..4).

Ports:
- iClk  in  1  system clock, rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iButtonEdge  in  P_BUTTON_WIDTH  one-cycle edge pulses, one bit per channel (from button_sync oButtonEdge).
- oEvtValid  out  1  FIFO head holds a valid event.
- oEvtIdx  out  P_IDX_WIDTH  channel index of the head event; valid only while oEvtValid=1.
- iEvtReady  in  1  consumer accepts the head event.
- oOverflow  out  1  sticky flag: at least one edge was dropped.
- iClrOverflow  in  1  synchronous clear of oOverflow.
- oCount  out  P_DEPTH_LOG2+1  number of events currently held in the FIFO.

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, pending=0, oEvtValid=0, oEvtIdx=0, oOverflow=0, oCount=0.
- Pending register (P_BUTTON_WIDTH bits):
  - Every cycle: pending_next = (pending & ~grant) | iButtonEdge.
  - grant is the one-hot lowest set bit of pending, when a push occurs.
- Push:
  - A push occurs when pending != 0 and (FIFO not full, or a pop occurs in the same cycle).
  - One push per cycle maximum; it writes the binary index of the granted bit.
- Pop:
  - Occurs when oEvtValid & iEvtReady.
  - The head advances at the same rising edge.
  - oEvtIdx is driven from the FIFO register (no combinational path from iButtonEdge).
- Latency:
  - An edge sampled at rising edge N sets pending at N.
  - The push happens at N+1.
  - oEvtValid=1 and oEvtIdx are valid after N+1 (2 cycles from the edge, FIFO initially empty).
- Ordering:
  - FIFO order is strict.
  - Within a batch of simultaneous edges, the lower index goes first.
  - A later edge on a lower channel can overtake still-pending higher channels; this is accepted.
- oCount:
  - +1 on push only, −1 on pop only, unchanged on push+pop together.
  - Never exceeds 2**P_DEPTH_LOG2.
- Full:
  - Pending bits hold (they are not dropped) until space frees.
  - Push+pop at full is allowed and keeps oCount = depth.
- Empty: oEvtValid=0; iEvtReady is ignored.
- Overflow:
  - oOverflow is set when an iButtonEdge bit arrives on a channel whose pending bit is already 1 and not granted that cycle; that edge merges and is counted as dropped.
  - An edge on a channel being granted in the same cycle re-arms pending and is not a drop.
  - iClrOverflow clears the flag, but a set event in the same cycle wins.
- oCount, pointers and pending bits are updated only on rising edges; there are no combinational outputs except decode of registered state.
- Reset asserted mid-operation: everything returns to reset values immediately; pending and buffered events are discarded.

Test Plan:
1. Reset, then a single pulse iButtonEdge=5'b00001 at cycle 0 with iEvtReady=0 -> oEvtValid=1, oEvtIdx=0, oCount=1 two cycles later; stays held. Set iEvtReady=1 -> pop the next cycle, oEvtValid=0, oCount=0.
2. Simultaneous pulse iButtonEdge=5'b10101, iEvtReady=0 -> pushes on 3 consecutive cycles. Then with iEvtReady=1 the FIFO pops idx 0, 2, 4 in that order; oOverflow=0.
3. Fill: pulse channels 0,1,2,3,4 on separate cycles with iEvtReady=0 -> oCount saturates at 4 with idx 0..3; pending bit 4 holds. One pop -> idx 4 pushed the same cycle, oCount stays 4.
4. Drop: with the FIFO full and pending[1]=1, pulse iButtonEdge=5'b00010 again -> oOverflow=1 and stays high. Pulse iClrOverflow -> 0. iClrOverflow together with a new drop -> oOverflow stays 1.
5. Continuous stream: iEvtReady=1, pulse a different channel every cycle for 20 cycles -> 20 events out in order, oCount <= 2, no overflow.
6. Assert iRst_n=0 asynchronously between clock edges with oCount=3 -> oEvtValid, oCount and oOverflow go to 0 before the next rising edge. After release, no stale event appears.
